// File: rtl/isqrt_pkg.sv
// Shared types and sizing helpers for the sequential integer square-root unit.
package isqrt_pkg;

  // Controller states: waiting for a radicand, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default root width used when the unit is not parameterised otherwise.
  localparam int SIZE_DEF = 4;

  // Iteration counter width for a given root width (counts SIZE-1 down to 0).
  function automatic int iter_width(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

  localparam int ITER_W = iter_width(SIZE_DEF);

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: bring down two radicand bits, trial
// subtract {q, 01}, keep the difference and shift in a 1 when it fits.
module isqrt_step #(
  parameter int SIZE = 4
) (
  input  logic [SIZE+1:0] r_i,
  input  logic [SIZE-1:0] q_i,
  input  logic [1:0]      bits_i,
  output logic [SIZE+1:0] r_o,
  output logic [SIZE-1:0] q_o
);

  logic [SIZE+3:0] r_shift;
  logic [SIZE+3:0] trial;
  logic            fits;

  // Trial subtraction, carried out at full width so the compare never wraps.
  always_comb begin
    r_shift = {r_i, bits_i};
    trial   = {2'b00, q_i, 2'b01};
    fits    = (r_shift >= trial);
    r_o     = fits ? (SIZE+2)'(r_shift - trial) : r_shift[SIZE+1:0];
    q_o     = {q_i[SIZE-2:0], fits};
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root, one root bit per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable data until that edge.
// in_ready/out_valid are registered and never depend combinationally on
// in_valid or out_ready.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   root,
  output logic [SIZE:0]     rem,
  output state_e            dbg_state
);

  localparam int CNT_W = iter_width(SIZE);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    iter_q, iter_d;
  logic [2*SIZE-1:0]   rad_q, rad_d;
  logic [SIZE+1:0]     r_q, r_d;
  logic [SIZE-1:0]     q_q, q_d;
  logic [SIZE-1:0]     root_q, root_d;
  logic [SIZE:0]       rem_q, rem_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [SIZE+1:0]     r_nxt;
  logic [SIZE-1:0]     q_nxt;

  isqrt_step #(.SIZE(SIZE)) u_step (
    .r_i    (r_q),
    .q_i    (q_q),
    .bits_i (rad_q[2*SIZE-1 -: 2]),
    .r_o    (r_nxt),
    .q_o    (q_nxt)
  );

  // Next-state, datapath and handshake decode; ready/valid follow the next state.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rad_d   = rad_q;
    r_d     = r_q;
    q_d     = q_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          rad_d   = in_data;
          r_d     = '0;
          q_d     = '0;
          iter_d  = CNT_W'(SIZE - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = {rad_q[2*SIZE-3:0], 2'b00};
        r_d    = r_nxt;
        q_d    = q_nxt;
        iter_d = iter_q - CNT_W'(1);
        if (iter_q == '0) begin
          root_d  = q_nxt;
          rem_d   = r_nxt[SIZE:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      rad_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      rad_q       <= rad_d;
      r_q         <= r_d;
      q_q         <= q_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign root      = root_q;
  assign rem       = rem_q;
  assign dbg_state = state_q;

endmodule
